// File: rtl/oled_data_sq_move_gen.sv
// Movable-square generator for the 96x64 OLED: button-steered square inside a framed region,
// registered RGB565 output. Define SQ_WRAP_EN to wrap at frame edges instead of stopping.
module oled_data_sq_move_gen #(
    parameter int unsigned BIG_LEFT = 35,
    parameter int unsigned BIG_TOP  = 19,
    parameter int unsigned BIG_SIZE = 25,
    parameter int unsigned SQ_SIZE  = 5,
    parameter int unsigned STEP_DIV = 2_000_000,
    parameter logic [15:0] COL_SQ   = 16'h07E0,
    parameter logic [15:0] COL_IDLE = 16'hF800,
    parameter logic [15:0] COL_MOVE = 16'hFFE0,
    parameter logic [15:0] COL_BG   = 16'h0000
) (
    input  logic        clock_100mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [6:0]  led_x,
    input  logic [5:0]  led_y,
    output logic [15:0] oled_data,
    output logic [6:0]  sq_x,
    output logic [5:0]  sq_y,
    output logic        moving
);

    localparam int unsigned CntW = $clog2(STEP_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(STEP_DIV - 1);

    // Legal range of the square's top-left corner
    localparam logic [6:0] XMin = 7'(BIG_LEFT);
    localparam logic [6:0] XMax = 7'(BIG_LEFT + BIG_SIZE - SQ_SIZE);
    localparam logic [5:0] YMin = 6'(BIG_TOP);
    localparam logic [5:0] YMax = 6'(BIG_TOP + BIG_SIZE - SQ_SIZE);
    localparam logic [6:0] XCen = 7'(BIG_LEFT + (BIG_SIZE - SQ_SIZE) / 2);
    localparam logic [5:0] YCen = 6'(BIG_TOP + (BIG_SIZE - SQ_SIZE) / 2);

    typedef enum logic [2:0] {StIdle, StMoveU, StMoveD, StMoveL, StMoveR} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      sq_x_q, sq_x_d;
    logic [5:0]      sq_y_q, sq_y_d;
    logic [15:0]     oled_q, oled_d;

    // Button bits: {C, U, D, L, R}
    logic [4:0] sync1_q, sync2_q, prev_q, btn_edge;
    logic [7:0] nx, ny, px, py;
    logic       out_of_frame, in_sq, in_frame;

    assign btn_edge = sync2_q & ~prev_q;

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            sq_x_q  <= XCen;
            sq_y_q  <= YCen;
            oled_q  <= '0;
        end else begin
            sync1_q <= {btnC, btnU, btnD, btnL, btnR};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sq_x_q  <= sq_x_d;
            sq_y_q  <= sq_y_d;
            oled_q  <= oled_d;
        end
    end

    // Candidate position in 8 bits so a step below 0 shows up as a large value
    always_comb begin
        nx = {1'b0, sq_x_q};
        ny = {2'b0, sq_y_q};
        case (state_q)
            StMoveU: ny = ny - 8'd1;
            StMoveD: ny = ny + 8'd1;
            StMoveL: nx = nx - 8'd1;
            StMoveR: nx = nx + 8'd1;
            default: ;
        endcase
        out_of_frame = (nx < {1'b0, XMin}) || (nx > {1'b0, XMax}) ||
                       (ny < {2'b0, YMin}) || (ny > {2'b0, YMax});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sq_x_d  = sq_x_q;
        sq_y_d  = sq_y_q;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            sq_x_d  = XCen;
            sq_y_d  = YCen;
        end else if (btn_edge != 5'b0) begin
            cnt_d = '0;
            if (btn_edge[4])      state_d = StIdle;
            else if (btn_edge[3]) state_d = StMoveU;
            else if (btn_edge[2]) state_d = StMoveD;
            else if (btn_edge[1]) state_d = StMoveL;
            else                  state_d = StMoveR;
        end else if (state_q != StIdle) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                if (!out_of_frame) begin
                    sq_x_d = nx[6:0];
                    sq_y_d = ny[5:0];
                end else begin
`ifdef SQ_WRAP_EN
                    case (state_q)
                        StMoveU: sq_y_d = YMax;
                        StMoveD: sq_y_d = YMin;
                        StMoveL: sq_x_d = XMax;
                        StMoveR: sq_x_d = XMin;
                        default: ;
                    endcase
`else
                    state_d = StIdle;
`endif
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        moving = (state_q != StIdle);
    end

    always_comb begin
        px       = {1'b0, led_x};
        py       = {2'b0, led_y};
        in_sq    = (px >= {1'b0, sq_x_q}) && (px < {1'b0, sq_x_q} + 8'(SQ_SIZE)) &&
                   (py >= {2'b0, sq_y_q}) && (py < {2'b0, sq_y_q} + 8'(SQ_SIZE));
        in_frame = (px >= 8'(BIG_LEFT)) && (px < 8'(BIG_LEFT + BIG_SIZE)) &&
                   (py >= 8'(BIG_TOP)) && (py < 8'(BIG_TOP + BIG_SIZE));
        if (!enable)       oled_d = COL_BG;
        else if (in_sq)    oled_d = COL_SQ;
        else if (in_frame) oled_d = moving ? COL_MOVE : COL_IDLE;
        else               oled_d = COL_BG;
    end

    assign oled_data = oled_q;
    assign sq_x      = sq_x_q;
    assign sq_y      = sq_y_q;

endmodule
